// File: rtl/toggle_pulse_rx.sv
`default_nettype none
// ============================================================================
//  Module   : toggle_pulse_rx
//  Purpose  : Receive end of a toggle-signalled event link. Every level change
//             on t_in is one event. Each change is recovered as a one-cycle
//             pulse and queued as a pending event behind a valid/ready
//             handshake. Events arriving while the queue is full are dropped
//             and flagged on a sticky overflow bit.
//
//  Parameters
//    DEPTH   maximum number of pending (unconsumed) events, >= 1
//    CNT_W   width of the head-event sequence number ev_seq
//
//  Ports
//    clk       in   1                 single clock, rising edge
//    rst_n     in   1                 synchronous active-low reset
//    t_in      in   1                 toggle input, one event per level change
//    ev_pulse  out  1                 one-cycle pulse per detected change
//    ev_valid  out  1                 at least one event is pending
//    ev_ready  in   1                 consumer takes the head event when valid
//    ev_seq    out  CNT_W             sequence number of the head event
//    pend_cnt  out  $clog2(DEPTH+1)   number of pending events
//    overflow  out  1                 sticky: an event was dropped
//    clr_ovf   in   1                 clears overflow (a new drop wins)
//
//  Build option
//    TOG_RX_SYNC_EN  defined   : t_in passes a 2-flop synchroniser, latency
//                                3 edges, ARM phase 2 cycles (async-safe)
//                    undefined : t_in used directly (must be clk-synchronous),
//                                latency 1 edge, ARM phase 1 cycle
//
//  Revision : 1.0  initial release
// ============================================================================
module toggle_pulse_rx #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         t_in,
   output logic                         ev_pulse,
   output logic                         ev_valid,
   input  logic                         ev_ready,
   output logic [CNT_W-1:0]             ev_seq,
   output logic [$clog2(DEPTH+1)-1:0]   pend_cnt,
   output logic                         overflow,
   input  logic                         clr_ovf
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int                  c_pend_w   = $clog2(DEPTH + 1);
   localparam logic [c_pend_w-1:0] c_depth    = c_pend_w'(DEPTH);
   localparam logic [c_pend_w-1:0] c_pend_one = c_pend_w'(1);
   localparam logic [CNT_W-1:0]    c_seq_one  = CNT_W'(1);

   // ------------------------------------------------------------------------
   // Input path
   //   w_t_cur    : the toggle level the detector works on
   //   w_t_settle : the value w_t_cur will hold after the next edge. During
   //                ARM t_prev is loaded from it so that, by the end of ARM,
   //                t_prev and t_cur agree even though the synchroniser is
   //                still filling from its reset value. This is what keeps a
   //                t_in held high through reset from looking like an event.
   // ------------------------------------------------------------------------
   logic w_t_cur;
   logic w_t_settle;

`ifdef TOG_RX_SYNC_EN
   localparam logic [1:0] c_arm_last = 2'd1;   // ARM lasts 2 cycles

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= t_in;
         s2_q <= s1_q;
      end
   end

   assign w_t_cur    = s2_q;
   assign w_t_settle = s1_q;
`else
   localparam logic [1:0] c_arm_last = 2'd0;   // ARM lasts 1 cycle

   assign w_t_cur    = t_in;
   assign w_t_settle = t_in;
`endif

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   typedef enum logic [0:0] {
      ST_ARM = 1'b0,
      ST_RUN = 1'b1
   } state_t;

   state_t                state_q;
   logic [1:0]            arm_cnt_q;
   logic                  t_prev_q;
   logic                  ev_pulse_q;
   logic                  ev_valid_q;
   logic [CNT_W-1:0]      ev_seq_q;
   logic [c_pend_w-1:0]   pend_q;
   logic                  ovf_q;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   logic                  w_edge;
   logic                  w_edge_run;
   logic                  w_take;
   logic                  w_full;
   logic                  w_drop;
   logic                  t_prev_d;
   logic [c_pend_w-1:0]   pend_d;
   logic [CNT_W-1:0]      ev_seq_d;
   logic                  ovf_d;

   always_comb begin
      w_edge     = w_t_cur ^ t_prev_q;
      // Edges seen while arming are start-up artefacts, never events.
      w_edge_run = w_edge & (state_q == ST_RUN);
      w_take     = ev_valid_q & ev_ready;
      w_full     = (pend_q == c_depth);
      // A take in the same cycle frees the slot, so a full queue only drops
      // when nothing is consumed alongside the new event.
      w_drop     = w_edge_run & ~w_take & w_full;

      t_prev_d   = (state_q == ST_ARM) ? w_t_settle : w_t_cur;

      pend_d = pend_q;
      if (w_edge_run && !w_take && !w_full) begin
         pend_d = pend_q + c_pend_one;
      end else if (!w_edge_run && w_take) begin
         pend_d = pend_q - c_pend_one;
      end

      ev_seq_d = w_take ? (ev_seq_q + c_seq_one) : ev_seq_q;

      // A drop in the same cycle as clr_ovf leaves the flag set.
      if (w_drop) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // ------------------------------------------------------------------------
   // FSM and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_ARM;
         arm_cnt_q  <= 2'd0;
         t_prev_q   <= 1'b0;
         ev_pulse_q <= 1'b0;
         ev_valid_q <= 1'b0;
         ev_seq_q   <= '0;
         pend_q     <= '0;
         ovf_q      <= 1'b0;
      end else begin
         t_prev_q <= t_prev_d;

         case (state_q)
            ST_ARM: begin
               ev_pulse_q <= 1'b0;
               if (arm_cnt_q == c_arm_last) begin
                  state_q <= ST_RUN;
               end else begin
                  arm_cnt_q <= arm_cnt_q + 2'd1;
               end
            end
            ST_RUN: begin
               ev_pulse_q <= w_edge;
            end
            default: begin
               state_q    <= ST_ARM;
               ev_pulse_q <= 1'b0;
            end
         endcase

         pend_q     <= pend_d;
         ev_valid_q <= (pend_d != '0);
         ev_seq_q   <= ev_seq_d;
         ovf_q      <= ovf_d;
      end
   end

   assign ev_pulse = ev_pulse_q;
   assign ev_valid = ev_valid_q;
   assign ev_seq   = ev_seq_q;
   assign pend_cnt = pend_q;
   assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_toggle_pulse_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_toggle_pulse_rx
//  Purpose  : Directed self-checking bench for toggle_pulse_rx (DEPTH=4,
//             CNT_W=8). Pulse latency and ARM length follow TOG_RX_SYNC_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_toggle_pulse_rx;

`ifdef TOG_RX_SYNC_EN
   localparam int LAT = 2;   // extra edges between edge k and the pulse
`else
   localparam int LAT = 0;
`endif

   logic       clk;
   logic       rst_n;
   logic       t_in;
   logic       ev_pulse;
   logic       ev_valid;
   logic       ev_ready;
   logic [7:0] ev_seq;
   logic [2:0] pend_cnt;
   logic       overflow;
   logic       clr_ovf;

   int checks   = 0;
   int failures = 0;
   int pulse_cnt = 0;
   int base;

   toggle_pulse_rx #(
      .DEPTH (4),
      .CNT_W (8)
   ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .t_in     (t_in),
      .ev_pulse (ev_pulse),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .ev_seq   (ev_seq),
      .pend_cnt (pend_cnt),
      .overflow (overflow),
      .clr_ovf  (clr_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counter, sampled on the falling edge.
   always @(negedge clk) begin
      if (ev_pulse === 1'b1) pulse_cnt = pulse_cnt + 1;
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut(input logic level);
      t_in  = level;
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (6) tick();
   endtask

   initial begin
      rst_n    = 1'b0;
      t_in     = 1'b1;
      ev_ready = 1'b0;
      clr_ovf  = 1'b0;

      // 1: t_in held high through reset -> no event
      repeat (2) tick();
      chk_eq("rst_pulse", ev_pulse, 0);
      chk_eq("rst_valid", ev_valid, 0);
      chk_eq("rst_seq", ev_seq, 0);
      chk_eq("rst_pend", pend_cnt, 0);
      chk_eq("rst_ovf", overflow, 0);
      base  = pulse_cnt;
      rst_n = 1'b1;
      repeat (20) tick();
      chk_eq("s1_pulses", pulse_cnt - base, 0);
      chk_eq("s1_valid", ev_valid, 0);
      chk_eq("s1_pend", pend_cnt, 0);

      // 2: single event, latency, then consume
      reset_dut(1'b0);
      t_in = 1'b1;
      tick();
      for (int i = 0; i < LAT; i++) begin
         chk_eq("s2_early_pulse", ev_pulse, 0);
         tick();
      end
      chk_eq("s2_pulse", ev_pulse, 1);
      chk_eq("s2_pend", pend_cnt, 1);
      chk_eq("s2_valid", ev_valid, 1);
      chk_eq("s2_seq", ev_seq, 0);
      tick();
      chk_eq("s2_pulse_width", ev_pulse, 0);
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
      chk_eq("s2_take_pend", pend_cnt, 0);
      chk_eq("s2_take_seq", ev_seq, 1);
      chk_eq("s2_take_valid", ev_valid, 0);

      // 3: five events into a 4-deep queue
      reset_dut(1'b0);
      base = pulse_cnt;
      for (int i = 0; i < 5; i++) begin
         t_in = ~t_in;
         repeat (4) tick();
         if (i == 3) begin
            chk_eq("s3_pend_full", pend_cnt, 4);
            chk_eq("s3_ovf_before", overflow, 0);
         end
      end
      chk_eq("s3_pulses", pulse_cnt - base, 5);
      chk_eq("s3_pend", pend_cnt, 4);
      chk_eq("s3_ovf", overflow, 1);
      chk_eq("s3_seq", ev_seq, 0);
      chk_eq("s3_valid", ev_valid, 1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      chk_eq("s3_clr_ovf", overflow, 0);
      chk_eq("s3_clr_pend", pend_cnt, 4);

      // 4: full queue, event and take on the same edge
      t_in = ~t_in;
      repeat (LAT) tick();
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
      chk_eq("s4_pulse", ev_pulse, 1);
      chk_eq("s4_pend", pend_cnt, 4);
      chk_eq("s4_seq", ev_seq, 1);
      chk_eq("s4_ovf", overflow, 0);
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
      chk_eq("s4_take_pend", pend_cnt, 3);
      chk_eq("s4_take_seq", ev_seq, 2);

      // 6: pend=3 with overflow set, then reset mid-operation
      t_in = ~t_in;
      repeat (4) tick();
      t_in = ~t_in;
      repeat (4) tick();
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
      chk_eq("s6_pre_pend", pend_cnt, 3);
      chk_eq("s6_pre_ovf", overflow, 1);
      rst_n = 1'b0;
      tick();
      chk_eq("s6_rst_pulse", ev_pulse, 0);
      chk_eq("s6_rst_valid", ev_valid, 0);
      chk_eq("s6_rst_seq", ev_seq, 0);
      chk_eq("s6_rst_pend", pend_cnt, 0);
      chk_eq("s6_rst_ovf", overflow, 0);
      base  = pulse_cnt;
      rst_n = 1'b1;
      repeat (10) tick();
      chk_eq("s6_arm_pulses", pulse_cnt - base, 0);
      chk_eq("s6_arm_pend", pend_cnt, 0);

      // 5: 300 events 3 cycles apart, consumer always ready -> seq wraps to 44
      ev_ready = 1'b1;
      base = pulse_cnt;
      for (int i = 0; i < 300; i++) begin
         t_in = ~t_in;
         repeat (3) tick();
      end
      repeat (5) tick();
      ev_ready = 1'b0;
      chk_eq("s5_pulses", pulse_cnt - base, 300);
      chk_eq("s5_seq", ev_seq, 44);
      chk_eq("s5_ovf", overflow, 0);
      chk_eq("s5_pend", pend_cnt, 0);
      chk_eq("s5_valid", ev_valid, 0);

      // Drop coinciding with clr_ovf: the drop wins
      for (int i = 0; i < 4; i++) begin
         t_in = ~t_in;
         repeat (4) tick();
      end
      chk_eq("prio_pend", pend_cnt, 4);
      t_in = ~t_in;
      repeat (LAT) tick();
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      chk_eq("prio_pulse", ev_pulse, 1);
      chk_eq("prio_ovf", overflow, 1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      chk_eq("prio_clr", overflow, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
